ar_mem_sequencer: RTL and testbench
===================================

// Module: ar_mem_sequencer
// PURPOSE
//  Sequences the CPU address register (AR) and memory port for two requesters:
//  instruction fetch (IF) and load/store (LS). It arbitrates, loads AR through
//  its write-enable, drives the memory handshake, and returns read data or an
//  error to the winner. Sits between the control unit and the AR/memory datapath.
// PARAMETERS
//  ADDR_W   32  address width, matching the AR width
//  DATA_W   32  memory data width
//  TIMEOUT  16  max ACCESS cycles without mem_ack before error; >=2; counter is clog2(TIMEOUT) bits
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  rst        in   1       synchronous reset, active-high
//  if_req     in   1       fetch request (level)
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       one-cycle pulse: fetch request accepted
//  if_valid   out  1       one-cycle pulse: fetch response on if_rdata
//  if_rdata   out  DATA_W  fetch read data
//  ls_req     in   1       load/store request (level)
//  ls_we      in   1       1=store, 0=load
//  ls_addr    in   ADDR_W  load/store address
//  ls_wdata   in   DATA_W  store data
//  ls_gnt     out  1       one-cycle pulse: LS request accepted
//  ls_valid   out  1       one-cycle pulse: LS response (load data or store done)
//  ls_rdata   out  DATA_W  load data (0 for stores)
//  rsp_err    out  1       qualifies if_valid/ls_valid: 1 = access timed out
//  we_AR      out  1       AR write enable
//  ar_addr    out  ADDR_W  AR input address
//  mem_req    out  1       memory access request
//  mem_we     out  1       memory write strobe
//  mem_wdata  out  DATA_W  memory write data
//  mem_ack    in   1       memory completion (one cycle)
//  mem_rdata  in   DATA_W  memory read data, valid with mem_ack
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, last_owner=LS, timeout counter=0,
//    all latched addr/data/rdata=0; every output 0. Applies mid-operation too:
//    an in-flight access is abandoned with no valid pulse; later mem_ack ignored.
//  - All outputs decode from registers only (Moore); no input-to-output comb path.
//  - FSM IDLE -> LOAD -> ACCESS -> RESP -> IDLE.
//  - IDLE: no req -> stay. Any req -> pick owner, latch owner's addr/we/wdata
//    (IF is always read, we=0), go LOAD.
//  - Arbitration: one req -> it wins. Both -> owner != last_owner (round-robin);
//    after reset IF wins the first tie. last_owner updates on entering LOAD.
//  - LOAD (1 cycle): we_AR=1, ar_addr=latched addr, owner's gnt=1. Requester
//    may drop/change req after gnt. AR holds the address from ACCESS onward.
//  - ACCESS: mem_req=1, mem_we=latched we, mem_wdata=latched wdata. Counter
//    cleared on entry, +1 per cycle without ack. mem_ack=1 -> capture mem_rdata
//    (0 if store), err=0, go RESP. Counter==TIMEOUT-1 and no ack -> rdata=0,
//    err=1, go RESP. Ack on the timeout cycle counts as success.
//  - RESP (1 cycle): owner's valid=1, owner's rdata=captured data,
//    rsp_err=err; other requester's valid=0. Go IDLE; new grant no earlier than
//    the cycle after RESP (no back-to-back bypass).
//  - if_rdata/ls_rdata hold last value until next response to that requester.
//  - mem_ack outside ACCESS ignored. mem_rdata sampled only with ack in ACCESS.
//  - Min latency: req high before edge 0 -> gnt+we_AR cycle 1, mem_req cycle 2,
//    ack cycle 2 -> valid cycle 3. Throughput: one access per 4 cycles.
// TESTING
//  1 Reset: rst=1 two cycles with if_req=ls_req=1 -> all outputs 0, busy=0;
//    rst low -> if_gnt next cycle (IF wins first tie).
//  2 IF read: if_addr=0x0000_0040, ack in 1st ACCESS cycle, mem_rdata=0xDEAD_BEEF
//    -> we_AR+ar_addr=0x40 cycle 1, mem_req cycle 2, if_valid, if_rdata=0xDEADBEEF,
//    rsp_err=0 cycle 3.
//  3 LS store: ls_we=1, ls_addr=0x100, ls_wdata=0x1234_5678, ack after 3 cycles
//    -> mem_we=1, mem_wdata=0x12345678 for 3 ACCESS cycles; ls_valid, ls_rdata=0.
//  4 Round-robin: both req held high 3 grants -> IF, LS, IF; each 4 cycles apart.
//  5 Timeout: TIMEOUT=16, no ack -> mem_req high exactly 16 cycles, then
//    valid with rsp_err=1, rdata=0; late mem_ack in IDLE ignored (no pulse).
//  6 Reset mid-ACCESS: rst pulse after 2 ACCESS cycles -> IDLE next cycle,
//    mem_req=0, no valid pulse; subsequent request completes normally.

Source files
------------

// File: rtl/ar_mem_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ar_mem_sequencer_if
//  Description : Request/response and memory-port bundle for the AR/memory
//                sequencer. The slave modport is the sequencer's view. The
//                master modport is the view of its environment: requesters,
//                the AR register and the memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface ar_mem_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // instruction-fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;

   // load/store requester
   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_valid;
   logic [DATA_W-1:0] ls_rdata;

   // shared response qualifier
   logic              rsp_err;

   // AR register load port
   logic              we_AR;
   logic [ADDR_W-1:0] ar_addr;

   // memory handshake
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   // status
   logic              busy;

   modport slave (
      input  if_req, if_addr,
      input  ls_req, ls_we, ls_addr, ls_wdata,
      input  mem_ack, mem_rdata,
      output if_gnt, if_valid, if_rdata,
      output ls_gnt, ls_valid, ls_rdata,
      output rsp_err, we_AR, ar_addr,
      output mem_req, mem_we, mem_wdata,
      output busy
   );

   modport master (
      output if_req, if_addr,
      output ls_req, ls_we, ls_addr, ls_wdata,
      output mem_ack, mem_rdata,
      input  if_gnt, if_valid, if_rdata,
      input  ls_gnt, ls_valid, ls_rdata,
      input  rsp_err, we_AR, ar_addr,
      input  mem_req, mem_we, mem_wdata,
      input  busy
   );
endinterface
`default_nettype wire

// File: rtl/ar_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ar_mem_sequencer
//  Description : Arbitrates between instruction fetch and load/store. It loads
//                the winning address into AR, runs one memory access with a
//                timeout, and returns the read data or an error to the winner.
//                This is a Moore machine: every output is a register.
//  Revision    : 1.0  initial release
// ============================================================================
module ar_mem_sequencer #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  wire logic        clk,
   input  wire logic        rst,
   ar_mem_sequencer_if.slave bus
);

   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   // Owner encoding: reset leaves last_owner at LS, so IF wins the first tie.
   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_LS = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_owner;
   logic              r_last_owner;
   logic              r_lat_we;
   logic [DATA_W-1:0] r_lat_wdata;
   logic [CNT_W-1:0]  r_cnt;

   // registered outputs
   logic              r_if_gnt;
   logic              r_if_valid;
   logic [DATA_W-1:0] r_if_rdata;
   logic              r_ls_gnt;
   logic              r_ls_valid;
   logic [DATA_W-1:0] r_ls_rdata;
   logic              r_rsp_err;
   logic              r_we_ar;
   logic [ADDR_W-1:0] r_ar_addr;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_busy;

   // arbitration and access-completion decode
   logic              w_any_req;
   logic              w_pick_ls;
   logic [ADDR_W-1:0] w_sel_addr;
   logic              w_sel_we;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_acc_done;
   logic              w_acc_err;
   logic [DATA_W-1:0] w_acc_data;

   // Round-robin pick. A lone request wins. On a tie, the requester that
   // did not win last time gets the grant. IF accesses are always reads.
   always_comb begin
      w_any_req   = bus.if_req | bus.ls_req;
      w_pick_ls   = bus.ls_req & (~bus.if_req | (r_last_owner == OWNER_IF));
      w_sel_addr  = w_pick_ls ? bus.ls_addr : bus.if_addr;
      w_sel_we    = w_pick_ls & bus.ls_we;
      w_sel_wdata = w_pick_ls ? bus.ls_wdata : '0;
   end

   // Decide how the access ends. An ack on the final timeout cycle still
   // counts as a success. Stores and timeouts return zero data.
   always_comb begin
      w_acc_done = 1'b0;
      w_acc_err  = 1'b0;
      w_acc_data = '0;
      if (r_state == ST_ACCESS) begin
         if (bus.mem_ack) begin
            w_acc_done = 1'b1;
            w_acc_data = r_lat_we ? '0 : bus.mem_rdata;
         end else if (r_cnt == CNT_LAST) begin
            w_acc_done = 1'b1;
            w_acc_err  = 1'b1;
         end
      end
   end

   // Sequencer FSM. Each output register is set on the edge that enters the
   // state where it must be high, so the outputs never depend on inputs
   // combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_owner      <= OWNER_IF;
         r_last_owner <= OWNER_LS;
         r_lat_we     <= 1'b0;
         r_lat_wdata  <= '0;
         r_cnt        <= '0;
         r_if_gnt     <= 1'b0;
         r_if_valid   <= 1'b0;
         r_if_rdata   <= '0;
         r_ls_gnt     <= 1'b0;
         r_ls_valid   <= 1'b0;
         r_ls_rdata   <= '0;
         r_rsp_err    <= 1'b0;
         r_we_ar      <= 1'b0;
         r_ar_addr    <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_wdata  <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_owner      <= w_pick_ls;
                  r_last_owner <= w_pick_ls;
                  r_lat_we     <= w_sel_we;
                  r_lat_wdata  <= w_sel_wdata;
                  r_ar_addr    <= w_sel_addr;
                  r_we_ar      <= 1'b1;
                  r_if_gnt     <= ~w_pick_ls;
                  r_ls_gnt     <= w_pick_ls;
                  r_busy       <= 1'b1;
                  r_state      <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               // AR captures the address this cycle. ar_addr then holds it.
               r_we_ar     <= 1'b0;
               r_if_gnt    <= 1'b0;
               r_ls_gnt    <= 1'b0;
               r_mem_req   <= 1'b1;
               r_mem_we    <= r_lat_we;
               r_mem_wdata <= r_lat_wdata;
               r_cnt       <= '0;
               r_state     <= ST_ACCESS;
            end

            ST_ACCESS: begin
               if (w_acc_done) begin
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_wdata <= '0;
                  r_rsp_err   <= w_acc_err;
                  if (r_owner == OWNER_LS) begin
                     r_ls_valid <= 1'b1;
                     r_ls_rdata <= w_acc_data;
                  end else begin
                     r_if_valid <= 1'b1;
                     r_if_rdata <= w_acc_data;
                  end
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_RESP: begin
               // Single-cycle response. A waiting requester is not granted
               // until IDLE, so successive accesses are four cycles apart.
               r_if_valid <= 1'b0;
               r_ls_valid <= 1'b0;
               r_rsp_err  <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.if_gnt    = r_if_gnt;
   assign bus.if_valid  = r_if_valid;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.ls_gnt    = r_ls_gnt;
   assign bus.ls_valid  = r_ls_valid;
   assign bus.ls_rdata  = r_ls_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.we_AR     = r_we_ar;
   assign bus.ar_addr   = r_ar_addr;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ar_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ar_mem_sequencer
//  Description : Self-checking bench for ar_mem_sequencer. Each test pushes
//                its expected responses into a scoreboard queue, and a
//                monitor pops and compares them whenever a valid pulse
//                appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ar_mem_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        is_ls;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t sb[$];
   rsp_t mon_exp;
   rsp_t mon_got;

   ar_mem_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   ar_mem_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // response monitor: every valid pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (bus.if_valid || bus.ls_valid) begin
         checks++;
         mon_got.is_ls = bus.ls_valid;
         mon_got.rdata = bus.ls_valid ? bus.ls_rdata : bus.if_rdata;
         mon_got.err   = bus.rsp_err;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got if_valid=%0b ls_valid=%0b, required no response",
                     bus.if_valid, bus.ls_valid);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_got !== mon_exp || (bus.if_valid && bus.ls_valid)) begin
               errors++;
               $display("FAIL response: got ls=%0b rdata=%h err=%0b (both=%0b), required ls=%0b rdata=%h err=%0b",
                        mon_got.is_ls, mon_got.rdata, mon_got.err, bus.if_valid && bus.ls_valid,
                        mon_exp.is_ls, mon_exp.rdata, mon_exp.err);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rsp(input logic is_ls, input logic [31:0] rdata, input logic err);
      rsp_t e;
      e.is_ls = is_ls;
      e.rdata = rdata;
      e.err   = err;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      bus.if_req  = 1'b1;
      bus.ls_req  = 1'b1;
      bus.if_addr = 32'h0000_0010;
      bus.ls_addr = 32'h0000_0020;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus.if_gnt, bus.if_valid, bus.if_rdata, bus.ls_gnt, bus.ls_valid, bus.ls_rdata,
           bus.rsp_err, bus.we_AR, bus.ar_addr, bus.mem_req, bus.mem_we, bus.mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got gnt=%0b/%0b we_AR=%0b ar=%h mem_req=%0b wdata=%h, required all 0",
                  bus.if_gnt, bus.ls_gnt, bus.we_AR, bus.ar_addr, bus.mem_req, bus.mem_wdata);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %0b, required 0", bus.busy);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.if_gnt, bus.ls_gnt, bus.we_AR, bus.ar_addr} !== {1'b1, 1'b0, 1'b1, 32'h0000_0010}) begin
         errors++;
         $display("FAIL reset_first_tie: got if_gnt=%0b ls_gnt=%0b we_AR=%0b ar=%h, required 1 0 1 00000010",
                  bus.if_gnt, bus.ls_gnt, bus.we_AR, bus.ar_addr);
      end
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hA5A5_0001;
      push_rsp(1'b0, 32'hA5A5_0001, 1'b0);
      tick();
      bus.mem_ack = 1'b0;
      tick();
   endtask

   task automatic test_if_read();
      bus.if_addr = 32'h0000_0040;
      bus.if_req  = 1'b1;
      tick();
      checks++;
      if ({bus.we_AR, bus.ar_addr, bus.if_gnt, bus.mem_req, bus.busy} !== {1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL if_load: got we_AR=%0b ar=%h gnt=%0b mem_req=%0b busy=%0b, required 1 00000040 1 0 1",
                  bus.we_AR, bus.ar_addr, bus.if_gnt, bus.mem_req, bus.busy);
      end
      bus.if_req = 1'b0;
      tick();
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.we_AR, bus.ar_addr} !== {1'b1, 1'b0, 1'b0, 32'h0000_0040}) begin
         errors++;
         $display("FAIL if_access: got mem_req=%0b mem_we=%0b we_AR=%0b ar=%h, required 1 0 0 00000040",
                  bus.mem_req, bus.mem_we, bus.we_AR, bus.ar_addr);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
      push_rsp(1'b0, 32'hDEAD_BEEF, 1'b0);
      tick();
      bus.mem_ack = 1'b0;
      checks++;
      if ({bus.if_valid, bus.if_rdata, bus.rsp_err, bus.mem_req} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL if_resp: got valid=%0b rdata=%h err=%0b mem_req=%0b, required 1 deadbeef 0 0",
                  bus.if_valid, bus.if_rdata, bus.rsp_err, bus.mem_req);
      end
      tick();
   endtask

   task automatic test_ls_store();
      bus.ls_we    = 1'b1;
      bus.ls_addr  = 32'h0000_0100;
      bus.ls_wdata = 32'h1234_5678;
      bus.ls_req   = 1'b1;
      tick();
      checks++;
      if ({bus.ls_gnt, bus.if_gnt, bus.ar_addr} !== {1'b1, 1'b0, 32'h0000_0100}) begin
         errors++;
         $display("FAIL ls_grant: got ls_gnt=%0b if_gnt=%0b ar=%h, required 1 0 00000100",
                  bus.ls_gnt, bus.if_gnt, bus.ar_addr);
      end
      bus.ls_req    = 1'b0;
      bus.mem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({bus.mem_req, bus.mem_we, bus.mem_wdata} !== {1'b1, 1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL ls_store_access[%0d]: got req=%0b we=%0b wdata=%h, required 1 1 12345678",
                     i, bus.mem_req, bus.mem_we, bus.mem_wdata);
         end
      end
      bus.mem_ack = 1'b1;
      push_rsp(1'b1, 32'h0000_0000, 1'b0);
      tick();
      bus.mem_ack = 1'b0;
      checks++;
      if ({bus.ls_valid, bus.ls_rdata, bus.mem_req, bus.if_rdata} !== {1'b1, 32'h0, 1'b0, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL ls_store_resp: got valid=%0b rdata=%h mem_req=%0b if_rdata=%h, required 1 00000000 0 deadbeef",
                  bus.ls_valid, bus.ls_rdata, bus.mem_req, bus.if_rdata);
      end
      bus.ls_we = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      int   n        = 0;
      int   last_cyc = 0;
      logic exp_ls;
      logic [31:0] exp_addr;
      bus.if_addr  = 32'h0000_0400;
      bus.ls_addr  = 32'h0000_0800;
      bus.ls_we    = 1'b0;
      bus.ls_wdata = 32'h0BAD_0BAD;
      bus.if_req   = 1'b1;
      bus.ls_req   = 1'b1;
      for (int cyc = 0; cyc < 40 && !(n == 3 && !bus.busy); cyc++) begin
         tick();
         bus.mem_ack = bus.mem_req;
         if (bus.if_gnt || bus.ls_gnt) begin
            exp_ls   = (n == 1);
            exp_addr = exp_ls ? 32'h0000_0800 : 32'h0000_0400;
            checks++;
            if ({bus.ls_gnt, bus.if_gnt, bus.ar_addr} !== {exp_ls, ~exp_ls, exp_addr}) begin
               errors++;
               $display("FAIL rr_owner[%0d]: got ls_gnt=%0b if_gnt=%0b ar=%h, required %0b %0b %h",
                        n, bus.ls_gnt, bus.if_gnt, bus.ar_addr, exp_ls, ~exp_ls, exp_addr);
            end
            if (n > 0) begin
               checks++;
               if (cyc - last_cyc != 4) begin
                  errors++;
                  $display("FAIL rr_spacing[%0d]: got %0d cycles, required 4", n, cyc - last_cyc);
               end
            end
            last_cyc      = cyc;
            bus.mem_rdata = 32'h0000_1000 + 32'(n);
            push_rsp(exp_ls, 32'h0000_1000 + 32'(n), 1'b0);
            n++;
            if (n == 3) begin
               bus.if_req = 1'b0;
               bus.ls_req = 1'b0;
            end
         end
      end
      bus.mem_ack = 1'b0;
      bus.if_req  = 1'b0;
      bus.ls_req  = 1'b0;
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL rr_grants: got %0d grants, required 3", n);
      end
      tick();
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      logic seen     = 1'b0;
      bus.if_addr   = 32'h0000_0080;
      bus.if_req    = 1'b1;
      bus.mem_rdata = 32'h5555_5555;
      push_rsp(1'b0, 32'h0000_0000, 1'b1);
      tick();
      bus.if_req = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (bus.mem_req) req_cycles++;
         if (bus.if_valid) seen = 1'b1;
      end
      checks++;
      if (!seen || req_cycles != 16) begin
         errors++;
         $display("FAIL timeout_len: got mem_req cycles=%0d seen_valid=%0b, required 16 1", req_cycles, seen);
      end
      checks++;
      if ({bus.rsp_err, bus.if_rdata} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL timeout_resp: got err=%0b rdata=%h, required 1 00000000", bus.rsp_err, bus.if_rdata);
      end
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h7777_7777;
      tick();
      bus.mem_ack = 1'b0;
      tick();
      checks++;
      if ({bus.if_valid, bus.ls_valid, bus.busy, bus.mem_req, bus.if_rdata} !== {4'b0000, 32'h0}) begin
         errors++;
         $display("FAIL late_ack: got if_valid=%0b ls_valid=%0b busy=%0b mem_req=%0b if_rdata=%h, required 0 0 0 0 00000000",
                  bus.if_valid, bus.ls_valid, bus.busy, bus.mem_req, bus.if_rdata);
      end
   endtask

   task automatic test_reset_mid_access();
      bus.ls_we   = 1'b0;
      bus.ls_addr = 32'h0000_0300;
      bus.ls_req  = 1'b1;
      tick();
      bus.ls_req = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.mem_req !== 1'b1) begin
         errors++;
         $display("FAIL mid_access_req: got %0b, required 1", bus.mem_req);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.mem_req, bus.busy, bus.ls_valid, bus.if_valid, bus.ar_addr} !== {4'b0000, 32'h0}) begin
         errors++;
         $display("FAIL mid_reset_idle: got mem_req=%0b busy=%0b ls_valid=%0b if_valid=%0b ar=%h, required 0 0 0 0 00000000",
                  bus.mem_req, bus.busy, bus.ls_valid, bus.if_valid, bus.ar_addr);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h9999_9999;
      tick();
      bus.mem_ack = 1'b0;
      tick();
      bus.if_addr = 32'h0000_0044;
      bus.if_req  = 1'b1;
      tick();
      checks++;
      if ({bus.if_gnt, bus.ar_addr} !== {1'b1, 32'h0000_0044}) begin
         errors++;
         $display("FAIL post_reset_grant: got if_gnt=%0b ar=%h, required 1 00000044", bus.if_gnt, bus.ar_addr);
      end
      bus.if_req = 1'b0;
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hCAFE_F00D;
      push_rsp(1'b0, 32'hCAFE_F00D, 1'b0);
      tick();
      bus.mem_ack = 1'b0;
      checks++;
      if ({bus.if_valid, bus.if_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
         errors++;
         $display("FAIL post_reset_resp: got valid=%0b rdata=%h, required 1 cafef00d", bus.if_valid, bus.if_rdata);
      end
      tick();
      tick();
   endtask

   initial begin
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.ls_req    = 1'b0;
      bus.ls_we     = 1'b0;
      bus.ls_addr   = '0;
      bus.ls_wdata  = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;

      test_reset();
      test_if_read();
      test_ls_store();
      test_round_robin();
      test_timeout();
      test_reset_mid_access();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending responses, required 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
